// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and per-digit correction helper for the
// BCD display scheduler.
package bcd_pkg;

  localparam int NCH_DEF   = 4;
  localparam int BIN_W_DEF = 10;
  localparam int DIG_W     = 4;
  localparam int NDIG      = 3;
  localparam int ITERS_DEF = BIN_W_DEF;  // one shift per operand bit

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    STORE
  } state_t;

  // Double-dabble correction: a digit of 5 or more would overflow past 9 when doubled.
  function automatic logic [DIG_W-1:0] dabble_digit(input logic [DIG_W-1:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/bcd_dabble.sv
// Iterative shift/add-3 binary-to-BCD converter: load captures the operand,
// each step performs one iteration, done flags that the current step is the last.
module bcd_dabble
  import bcd_pkg::*;
#(
  parameter int BIN_W = BIN_W_DEF,
  parameter int ITERS = ITERS_DEF,
  parameter int NDIG_INT = NDIG
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic                      step,
  input  logic [BIN_W-1:0]          bin,
  output logic [NDIG_INT*DIG_W-1:0] bcd,
  output logic                      done
);

  localparam int BCD_W = NDIG_INT * DIG_W;
  localparam int SH_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(ITERS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERS - 1);

  logic [SH_W-1:0]  sh;
  logic [SH_W-1:0]  sh_adj;
  logic [CNT_W-1:0] cnt;

  always_comb begin
    sh_adj = sh;
    for (int d = 0; d < NDIG_INT; d++) begin
      sh_adj[BIN_W + d*DIG_W +: DIG_W] = dabble_digit(sh[BIN_W + d*DIG_W +: DIG_W]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh  <= '0;
      cnt <= '0;
    end else if (load) begin
      sh  <= {{BCD_W{1'b0}}, bin};
      cnt <= '0;
    end else if (step) begin
      sh  <= {sh_adj[SH_W-2:0], 1'b0};
      cnt <= cnt + 1'b1;
    end
  end

  assign bcd  = sh[SH_W-1 -: BCD_W];
  assign done = (cnt == LAST);

endmodule

// File: rtl/bcd_display_scheduler.sv
// Round-robin scheduler sharing one double-dabble converter across NCH channels.
// Define BCD_OVERLOAD_EN to saturate operands above 999 to 0x999 and flag overload.
module bcd_display_scheduler
  import bcd_pkg::*;
#(
  parameter int NCH   = NCH_DEF,
  parameter int BIN_W = BIN_W_DEF
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic [NCH-1:0]       req,
  input  logic [NCH*BIN_W-1:0] bin_in,
  output logic [NCH-1:0]       ack,
  output logic [NCH*12-1:0]    bcd_out,
  output logic [NCH-1:0]       valid,
  output logic [NCH-1:0]       overload,
  output logic                 busy
);

  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int RES_W = NDIG * DIG_W;
  localparam logic [IDX_W:0] NCH_L = (IDX_W+1)'(NCH);
`ifdef BCD_OVERLOAD_EN
  localparam int DAB_DIG = NDIG + 1;
`else
  localparam int DAB_DIG = NDIG;  // thousands carry falls off the top: value mod 1000
`endif
  localparam int DAB_W = DAB_DIG * DIG_W;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] win;
  logic [IDX_W-1:0] nxt_ptr;
  logic [IDX_W:0]   cand;
  logic [IDX_W:0]   nxt;
  logic             found;
  logic [NCH-1:0]   elig;
  logic [DAB_W-1:0] dab_bcd;
  logic             dab_done;
  logic [RES_W-1:0] res;

  // A channel whose ack is in flight must not be re-granted on stale req.
  assign elig = req & ~ack;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    found = 1'b0;
    win   = rr_ptr;
    cand  = '0;
    for (int k = 0; k < NCH; k++) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (cand >= NCH_L) cand = cand - NCH_L;
      if (!found && elig[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        win   = cand[IDX_W-1:0];
      end
    end
    nxt = {1'b0, win} + 1'b1;
    if (nxt == NCH_L) nxt = '0;
    nxt_ptr = nxt[IDX_W-1:0];
  end

  bcd_dabble #(
    .BIN_W   (BIN_W),
    .ITERS   (BIN_W),
    .NDIG_INT(DAB_DIG)
  ) u_dabble (
    .clk (CLOCK_50),
    .rst (reset),
    .load(state == LOAD),
    .step(state == SHIFT),
    .bin (bin_in[grant*BIN_W +: BIN_W]),
    .bcd (dab_bcd),
    .done(dab_done)
  );

`ifdef BCD_OVERLOAD_EN
  logic res_ovl;
  logic [NCH-1:0] ovl_q;

  always_comb begin
    res     = dab_bcd[RES_W-1:0];
    res_ovl = 1'b0;
    if (|dab_bcd[DAB_W-1 -: DIG_W]) begin
      res     = {NDIG{4'h9}};
      res_ovl = 1'b1;
    end
  end

  assign overload = ovl_q;
`else
  assign res      = dab_bcd;
  assign overload = '0;
`endif

  // NOTE: the per-channel result bank is a handful of flops, so it takes the
  // async reset like any other register rather than being left uninitialised.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      ack     <= '0;
      rr_ptr  <= '0;
      grant   <= '0;
      bcd_out <= '0;
      valid   <= '0;
`ifdef BCD_OVERLOAD_EN
      ovl_q   <= '0;
`endif
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            grant  <= win;
            rr_ptr <= nxt_ptr;
            state  <= LOAD;
            busy   <= 1'b1;
          end
        end
        LOAD: state <= SHIFT;
        SHIFT: begin
          if (dab_done) state <= STORE;
        end
        STORE: begin
          state                        <= IDLE;
          busy                         <= 1'b0;
          ack[grant]                   <= 1'b1;
          valid[grant]                 <= 1'b1;
          bcd_out[grant*RES_W +: RES_W] <= res;
`ifdef BCD_OVERLOAD_EN
          ovl_q[grant]                 <= res_ovl;
`endif
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/bcd_display_scheduler.md
BCD_DISPLAY_SCHEDULER -- requirements
Module: bcd_display_scheduler

Interface
REQ-001 Parameters SHALL be: NCH, default 4, number of requesters; BIN_W, default 10, binary operand width.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 CLOCK_50  in  1  system clock, all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 req  in  NCH  per-channel conversion request, held high until the matching ack.
REQ-006 bin_in  in  NCH*BIN_W  channel i operand at bits [i*BIN_W +: BIN_W], stable while req[i] is high.
REQ-007 ack  out  NCH  one-cycle completion pulse per channel.
REQ-008 bcd_out  out  NCH*12  per-channel hundreds/tens/units digits at [i*12 +: 12], as [11:8]/[7:4]/[3:0].
REQ-009 valid  out  NCH  sticky: channel holds at least one completed result.
REQ-010 overload  out  NCH  last operand for the channel exceeded 999.
REQ-011 busy  out  1  high whenever state is not IDLE.

Function
REQ-012 One shared iterative double-dabble converter SHALL serve all channels, one conversion at a time.
REQ-013 FSM states SHALL be IDLE, LOAD, SHIFT and STORE.
REQ-014 Transitions: IDLE->LOAD on any unmasked req; LOAD->SHIFT; SHIFT->STORE after BIN_W iterations; STORE->IDLE.
REQ-015 Arbitration SHALL be round-robin; after channel g is granted, search priority starts at g+1 mod NCH.
REQ-016 Simultaneous requests SHALL be resolved by the round-robin pointer only.
REQ-017 The granted index and operand SHALL be captured at the LOAD edge; later bin_in changes are ignored.
REQ-018 Timing: req sampled in IDLE at edge E0; operand loaded at E1; iterations at E2..E11; result written at E12.
REQ-019 At E12, bcd_out for the granted channel SHALL update, valid[g] SHALL set, and ack[g] SHALL be high for exactly one cycle.
REQ-020 Minimum spacing between acks SHALL be 13 cycles.
REQ-021 req[i] SHALL be masked from arbitration while ack[i] is high.
REQ-022 If req[g] drops mid-conversion, the conversion SHALL still complete, write its result and pulse ack.
REQ-023 Each iteration SHALL add 3 to every BCD digit >= 5, then shift left 1 bit.
REQ-024 Operands 1000..1023 produce a thousands digit internally; handling is set by REQ-029/REQ-030.
REQ-025 Channels not being written SHALL hold bcd_out, valid and overload unchanged.

Reset
REQ-026 Reset SHALL asynchronously clear ack, bcd_out, valid, overload and busy to 0, set state to IDLE and set the round-robin pointer to channel 0.
REQ-027 Reset mid-conversion SHALL abort the conversion with no ack and no result write.
REQ-028 Deasserting reset SHALL take effect at the next clock edge.

Configuration
REQ-029 With BCD_OVERLOAD_EN defined: a nonzero thousands digit SHALL force that channel's result to 0x999 and set overload[g]=1; otherwise overload[g]=0.
REQ-030 Without BCD_OVERLOAD_EN: the thousands digit SHALL be discarded (result = value mod 1000), and overload SHALL be constant 0.

Structure
REQ-031 Package bcd_pkg SHALL hold the NCH and BIN_W defaults, the digit width (4), the digit count (3), the FSM state enum and the iteration count.
REQ-032 Sub-module bcd_dabble SHALL hold the shift/add-3 register and iteration counter, with load/step/done controls.
REQ-033 Arbiter, FSM and result registers SHALL reside in the top level.

Verification
REQ-034 Reset: assert reset for 3 cycles -> all outputs 0, busy=0.
REQ-035 Single request: req[0]=1, bin 379 -> ack[0] pulses exactly once, 12 edges after sampling; bcd_out[11:0]=0x379; valid[0]=1.
REQ-036 Contention: req[0]=123 and req[2]=456 raised in the same cycle -> ch0 acked first, ch2 acked 13 cycles later, next grant priority starts at ch3.
REQ-037 Boundaries: 0 -> 0x000; 999 -> 0x999 with overload=0; 1023 -> 0x999 and overload=1 with the macro, 0x023 and overload=0 without it.
REQ-038 Reset abort: reset asserted during the 5th SHIFT cycle of a ch1 request -> no ack, valid[1]=0; following requests on ch1 and ch3 are served ch1 first.
REQ-039 Dropped request: req[3] released 4 cycles after grant -> result still written and ack[3] pulses once.
